// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame monitor: nominal 640x480@60 raster
// defaults, monitor state encoding, CRC polynomial and a saturating helper.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int H_TOTAL_DEF  = 800;
  localparam int V_TOTAL_DEF  = 525;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;

  typedef enum logic [1:0] {
    WAIT_VSYNC = 2'd0,
    ARMED      = 2'd1,
    ACTIVE     = 2'd2
  } mon_state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    if (v == 10'd1023) begin
      return v;
    end else begin
      return v + 10'd1;
    end
  endfunction

endpackage

// File: rtl/vga_frame_crc32.sv
// Combinational CRC-32 step that folds one 24-bit pixel into the running CRC,
// MSB first. Only instantiated when VGA_MON_CRC_EN is defined.
module vga_frame_crc32
  import vga_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [23:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_s;

  // Bit-serial CRC unrolled over the 24 pixel bits
  always_comb begin
    crc_s = crc_in;
    for (int i = 23; i >= 0; i--) begin
      if (crc_s[31] ^ data[i]) begin
        crc_s = {crc_s[30:0], 1'b0} ^ CRC_POLY;
      end else begin
        crc_s = {crc_s[30:0], 1'b0};
      end
    end
    crc_out = crc_s;
  end

endmodule

// File: rtl/vga_frame_monitor.sv
// Receive-side VGA monitor: recovers pixel coordinates, frame statistics and
// sticky raster timing errors. Define VGA_MON_CRC_EN for a CRC-32 frame_sum.
module vga_frame_monitor
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   H_TOTAL  = H_TOTAL_DEF,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_en,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [23:0] vga_data,
  input  logic        clr_err,
  output logic        locked,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic [31:0] frame_sum,
  output logic        err_hpix,
  output logic        err_vlines,
  output logic        err_htotal
);

  localparam logic [9:0]  H_ACT_L = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT_L = 10'(V_ACTIVE);
  localparam logic [10:0] H_TOT_L = 11'(H_TOTAL);
`ifdef VGA_MON_CRC_EN
  localparam logic [31:0] SUM_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] SUM_XOR  = 32'hFFFFFFFF;
`else
  localparam logic [31:0] SUM_INIT = 32'h00000000;
  localparam logic [31:0] SUM_XOR  = 32'h00000000;
`endif

  logic        en_r, hs_act_r, vs_act_r, clr_r;
  logic [23:0] data_r;
  logic        en_prev_r, hs_prev_r, vs_prev_r;
  mon_state_e  state_r, state_s;
  logic [9:0]  x_r, x_s, y_r, y_s, x_n_s, y_n_s;
  logic [31:0] sum_r, sum_s, sum_n_s, sum_pix_s;
  logic [10:0] hcnt_r, hcnt_s;
  logic        hseen_r, hseen_s;
  logic        vs_edge_s, hs_edge_s, take_pix_s, close_line_s;
  logic        hpix_ev_s, vl_ev_s, ht_ev_s;
  logic        locked_s, pix_valid_s, frame_done_s;
  logic [9:0]  pix_x_s, pix_y_s;
  logic [23:0] pix_data_s;
  logic [15:0] frame_cnt_s;
  logic [31:0] frame_sum_s;
  logic        err_hpix_s, err_vlines_s, err_htotal_s;

`ifdef VGA_MON_CRC_EN
  vga_frame_crc32 u_crc (
    .crc_in  (sum_r),
    .data    (data_r),
    .crc_out (sum_pix_s)
  );
`else
  assign sum_pix_s = sum_r + {8'd0, data_r};
`endif

  // Next-state: frame FSM, pixel/line counters, H_SYNC period and sticky errors
  always_comb begin
    vs_edge_s    = vs_act_r & ~vs_prev_r;
    hs_edge_s    = hs_act_r & ~hs_prev_r;
    state_s      = state_r;
    x_s          = x_r;
    y_s          = y_r;
    sum_s        = sum_r;
    x_n_s        = x_r;
    y_n_s        = y_r;
    sum_n_s      = sum_r;
    take_pix_s   = 1'b0;
    close_line_s = 1'b0;
    hpix_ev_s    = 1'b0;
    vl_ev_s      = 1'b0;
    ht_ev_s      = 1'b0;
    hcnt_s       = hcnt_r;
    hseen_s      = hseen_r;
    locked_s     = locked;
    pix_valid_s  = 1'b0;
    pix_x_s      = pix_x;
    pix_y_s      = pix_y;
    pix_data_s   = pix_data;
    frame_done_s = 1'b0;
    frame_cnt_s  = frame_cnt;
    frame_sum_s  = frame_sum;

    case (state_r)
      WAIT_VSYNC: begin
        if (vs_edge_s) begin
          state_s  = ARMED;
          locked_s = 1'b1;
          x_s      = 10'd0;
          y_s      = 10'd0;
          sum_s    = SUM_INIT;
        end else begin
          state_s  = WAIT_VSYNC;
        end
      end
      ARMED, ACTIVE: begin
        // In ARMED a coinciding V_SYNC edge wins: that is a zero-line frame
        take_pix_s = en_r & ((state_r == ACTIVE) | ~vs_edge_s);
        if (take_pix_s) begin
          pix_valid_s = 1'b1;
          pix_x_s     = x_r;
          pix_y_s     = y_r;
          pix_data_s  = data_r;
          x_n_s       = sat_inc10(x_r);
          sum_n_s     = sum_pix_s;
          state_s     = ACTIVE;
        end else begin
          pix_valid_s = 1'b0;
        end
        close_line_s = (state_r == ACTIVE) &
                       ((en_prev_r & ~en_r) | (vs_edge_s & en_r));
        if (close_line_s) begin
          hpix_ev_s = (x_n_s != H_ACT_L);
          y_n_s     = sat_inc10(y_r);
          x_n_s     = 10'd0;
        end else begin
          hpix_ev_s = 1'b0;
        end
        if (vs_edge_s) begin
          vl_ev_s      = (y_n_s != V_ACT_L);
          frame_done_s = 1'b1;
          frame_sum_s  = sum_n_s ^ SUM_XOR;
          frame_cnt_s  = frame_cnt + 16'd1;
          x_s          = 10'd0;
          y_s          = 10'd0;
          sum_s        = SUM_INIT;
          state_s      = ARMED;
        end else begin
          x_s   = x_n_s;
          y_s   = y_n_s;
          sum_s = sum_n_s;
        end
      end
      default: begin
        state_s = WAIT_VSYNC;
      end
    endcase

    if (state_r != WAIT_VSYNC) begin
      if (hs_edge_s) begin
        ht_ev_s = hseen_r & (hcnt_r != H_TOT_L);
        hcnt_s  = 11'd1;
        hseen_s = 1'b1;
      end else if (hcnt_r != 11'd2047) begin
        hcnt_s  = hcnt_r + 11'd1;
      end else begin
        hcnt_s  = hcnt_r;
      end
    end else begin
      hcnt_s  = 11'd0;
      hseen_s = 1'b0;
    end

    // A new error event outranks a simultaneous clear
    err_hpix_s   = (err_hpix   & ~clr_r) | hpix_ev_s;
    err_vlines_s = (err_vlines & ~clr_r) | vl_ev_s;
    err_htotal_s = (err_htotal & ~clr_r) | ht_ev_s;
  end

  // Input sampling, state registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      en_r       <= 1'b0;
      hs_act_r   <= 1'b0;
      vs_act_r   <= 1'b0;
      clr_r      <= 1'b0;
      data_r     <= 24'd0;
      en_prev_r  <= 1'b0;
      hs_prev_r  <= 1'b0;
      vs_prev_r  <= 1'b0;
      state_r    <= WAIT_VSYNC;
      x_r        <= 10'd0;
      y_r        <= 10'd0;
      sum_r      <= 32'd0;
      hcnt_r     <= 11'd0;
      hseen_r    <= 1'b0;
      locked     <= 1'b0;
      pix_valid  <= 1'b0;
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      pix_data   <= 24'd0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      frame_sum  <= 32'd0;
      err_hpix   <= 1'b0;
      err_vlines <= 1'b0;
      err_htotal <= 1'b0;
    end else begin
      en_r       <= vga_en;
      hs_act_r   <= (h_sync == SYNC_POL);
      vs_act_r   <= (v_sync == SYNC_POL);
      clr_r      <= clr_err;
      data_r     <= vga_data;
      en_prev_r  <= en_r;
      hs_prev_r  <= hs_act_r;
      vs_prev_r  <= vs_act_r;
      state_r    <= state_s;
      x_r        <= x_s;
      y_r        <= y_s;
      sum_r      <= sum_s;
      hcnt_r     <= hcnt_s;
      hseen_r    <= hseen_s;
      locked     <= locked_s;
      pix_valid  <= pix_valid_s;
      pix_x      <= pix_x_s;
      pix_y      <= pix_y_s;
      pix_data   <= pix_data_s;
      frame_done <= frame_done_s;
      frame_cnt  <= frame_cnt_s;
      frame_sum  <= frame_sum_s;
      err_hpix   <= err_hpix_s;
      err_vlines <= err_vlines_s;
      err_htotal <= err_htotal_s;
    end
  end

endmodule

// File: tb/tb_vga_frame_monitor.sv
// Self-checking bench for vga_frame_monitor on a shrunken raster
// (8 pixels x 6 lines, 14 clocks per line) with the additive checksum.
module tb_vga_frame_monitor;

  localparam int HA     = 8;
  localparam int VA     = 6;
  localparam int HT     = 14;
  localparam int HS_OFF = 10;

  logic        clk = 1'b0;
  logic        rst, vga_en, h_sync, v_sync, clr_err;
  logic [23:0] vga_data;
  logic        locked, pix_valid, frame_done;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_data;
  logic [15:0] frame_cnt;
  logic [31:0] frame_sum;
  logic        err_hpix, err_vlines, err_htotal;

  vga_frame_monitor #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_TOTAL  (HT),
    .SYNC_POL (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .vga_en     (vga_en),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .vga_data   (vga_data),
    .clr_err    (clr_err),
    .locked     (locked),
    .pix_valid  (pix_valid),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .frame_sum  (frame_sum),
    .err_hpix   (err_hpix),
    .err_vlines (err_vlines),
    .err_htotal (err_htotal)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Expected-pixel pipeline and event counters
  typedef struct {
    logic        en;
    logic        exp;
    int          x;
    int          y;
    logic [23:0] d;
  } pipe_t;

  pipe_t s1, s2;
  logic  armed = 1'b0;
  int    cur_x = 0, cur_y = 0;
  int    done_cnt = 0;
  int    pix_bad = 0;
  logic  rst_hit = 1'b0;
  logic  rst_zero_ok = 1'b0;
  logic  vexp;

  always @(posedge clk) begin
    rst_hit = rst;
    if (rst) begin
      s1.exp = 1'b0;
      s2.exp = 1'b0;
    end else begin
      s2 = s1;
      s1.en  = vga_en;
      s1.exp = armed;
      s1.x   = cur_x;
      s1.y   = cur_y;
      s1.d   = vga_data;
    end
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_cnt++;
    if (rst_hit)
      rst_zero_ok = (locked === 1'b0) && (pix_valid === 1'b0) && (pix_x === 10'd0) &&
                    (pix_y === 10'd0) && (pix_data === 24'd0) && (frame_done === 1'b0) &&
                    (frame_cnt === 16'd0) && (frame_sum === 32'd0) && (err_hpix === 1'b0) &&
                    (err_vlines === 1'b0) && (err_htotal === 1'b0);
    vexp = s2.en & s2.exp;
    if (pix_valid !== vexp) begin
      pix_bad++;
    end else if (vexp && (pix_x !== s2.x[9:0] || pix_y !== s2.y[9:0] || pix_data !== s2.d)) begin
      pix_bad++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One frame: n_lines active lines, one blank, two V_SYNC lines, one blank
  task automatic drive_frame(input int n_lines, input int bad_pix, input int bad_htot,
                             input int clr_line, input int rst_line, input bit cpix);
    int len, npx;
    for (int ln = 0; ln < n_lines + 4; ln++) begin
      len = (ln == bad_htot) ? HT - 1 : HT;
      npx = (ln < n_lines) ? ((ln == bad_pix) ? HA - 1 : HA) : 0;
      for (int c = 0; c < len; c++) begin
        @(posedge clk);
        #1;
        vga_en   = (c < npx);
        cur_x    = c;
        cur_y    = ln;
        vga_data = cpix ? 24'd1 : 24'(ln * HA + c);
        h_sync   = !(c == HS_OFF || c == HS_OFF + 1);
        v_sync   = !(ln == n_lines + 1 || ln == n_lines + 2);
        clr_err  = (ln == clr_line && c == HS_OFF);
        rst      = (ln == rst_line && c == 3);
        if (rst) armed = 1'b0;
        if (ln == n_lines + 1 && c == 0) armed = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  typedef struct {
    int n_lines, bad_pix, bad_htot, clr_line, cpix;
    int exp_done, exp_cnt, exp_hpix, exp_vl, exp_ht, exp_sum;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // lines, bad_pix, bad_htot, clr_line, const | done, cnt, hpix, vlines, htotal, sum
    vecs[0]  = '{6, -1, -1, -1, 0,  0,  0, 0, 0, 0,    0};
    vecs[1]  = '{6, -1, -1, -1, 0,  1,  1, 0, 0, 0, 1128};
    vecs[2]  = '{6, -1, -1, -1, 0,  2,  2, 0, 0, 0, 1128};
    vecs[3]  = '{6, -1, -1, -1, 1,  3,  3, 0, 0, 0,   48};
    vecs[4]  = '{6,  2, -1, -1, 0,  4,  4, 1, 0, 0, 1105};
    vecs[5]  = '{6, -1, -1,  0, 0,  5,  5, 0, 0, 0, 1128};
    vecs[6]  = '{5, -1, -1, -1, 0,  6,  6, 0, 1, 0,  780};
    vecs[7]  = '{7, -1, -1,  0, 0,  7,  7, 0, 1, 0, 1540};
    vecs[8]  = '{6, -1, -1,  0, 0,  8,  8, 0, 0, 0, 1128};
    vecs[9]  = '{6, -1,  3,  4, 0,  9,  9, 0, 0, 1, 1128};
    vecs[10] = '{6, -1, -1,  0, 0, 10, 10, 0, 0, 0, 1128};

    s1 = '{1'b0, 1'b0, 0, 0, 24'd0};
    s2 = '{1'b0, 1'b0, 0, 0, 24'd0};
    rst = 1'b1; vga_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
    vga_data = 24'd0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_locked",    64'(locked),    64'd0);
    check("reset_pix_valid", 64'(pix_valid), 64'd0);
    check("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check("reset_frame_sum", 64'(frame_sum), 64'd0);
    check("reset_errors",    64'({err_hpix, err_vlines, err_htotal}), 64'd0);

    for (int i = 0; i < 11; i++) begin
      drive_frame(vecs[i].n_lines, vecs[i].bad_pix, vecs[i].bad_htot,
                  vecs[i].clr_line, -1, vecs[i].cpix[0]);
      check($sformatf("v%0d_locked", i),     64'(locked),     64'd1);
      check($sformatf("v%0d_done_cnt", i),   64'(done_cnt),   64'(vecs[i].exp_done));
      check($sformatf("v%0d_frame_cnt", i),  64'(frame_cnt),  64'(vecs[i].exp_cnt));
      check($sformatf("v%0d_frame_sum", i),  64'(frame_sum),  64'(vecs[i].exp_sum));
      check($sformatf("v%0d_err_hpix", i),   64'(err_hpix),   64'(vecs[i].exp_hpix));
      check($sformatf("v%0d_err_vlines", i), 64'(err_vlines), 64'(vecs[i].exp_vl));
      check($sformatf("v%0d_err_htotal", i), 64'(err_htotal), 64'(vecs[i].exp_ht));
      check($sformatf("v%0d_pix_stream", i), 64'(pix_bad),    64'd0);
    end

    // Mid-frame reset after a short line: everything clears, relock without a frame
    rst_zero_ok = 1'b0;
    drive_frame(6, 1, -1, -1, 2, 1'b0);
    check("rst_outputs_zero",  64'(rst_zero_ok), 64'd1);
    check("rst_relock",        64'(locked),      64'd1);
    check("rst_no_done",       64'(done_cnt),    64'd10);
    check("rst_frame_cnt",     64'(frame_cnt),   64'd0);
    check("rst_err_hpix",      64'(err_hpix),    64'd0);
    drive_frame(6, -1, -1, -1, -1, 1'b0);
    check("post_rst_done",      64'(done_cnt),  64'd11);
    check("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);
    check("post_rst_frame_sum", 64'(frame_sum), 64'd1128);
    check("post_rst_pix",       64'(pix_bad),   64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
